// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the bitstream source (master) and the ccff loader (slave).
interface ccff_chain_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (
        output bs_data,
        output bs_valid,
        input  bs_ready
    );

    modport slave (
        input  bs_data,
        input  bs_valid,
        output bs_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words LSB-first into a fixed-length ccff chain and counts the ones
// returned on the chain tail as a readback checksum of the previous contents.
module ccff_chain_loader #(
    parameter int unsigned  CHAIN_LEN = 12,
    parameter int unsigned  DATA_W    = 8,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic               prog_clk,
    input  logic               pReset,
    input  logic               start,
    input  logic               abort,
    ccff_chain_loader_if.slave bs,
    output logic               ccff_head,
    output logic               ccff_shift_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   tail_ones
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]   nbits_q, nbits_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   tail_ones_q, tail_ones_d;
    logic               err_q, err_d;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            nbits_q     <= '0;
            remaining_q <= '0;
            tail_ones_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            nbits_q     <= nbits_d;
            remaining_q <= remaining_d;
            tail_ones_q <= tail_ones_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        nbits_d     = nbits_q;
        remaining_d = remaining_q;
        tail_ones_d = tail_ones_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    remaining_d = CNT_W'(CHAIN_LEN);
                    tail_ones_d = '0;
                    err_d       = 1'b0;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (bs.bs_valid) begin
                    sr_d = bs.bs_data;
                    // The last word may be partial; its upper bits are never shifted out.
                    if (32'(remaining_q) >= DATA_W) begin
                        nbits_d = CNT_W'(DATA_W);
                    end else begin
                        nbits_d = remaining_q;
                    end
                    state_d = StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    sr_d        = sr_q >> 1;
                    nbits_d     = nbits_q - CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (ccff_tail && (tail_ones_q != CNT_W'(CHAIN_LEN))) begin
                        tail_ones_d = tail_ones_q + CNT_W'(1);
                    end
                    if (nbits_q == CNT_W'(1)) begin
                        state_d = (remaining_q == CNT_W'(1)) ? StDone : StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode flopped state only, so no input reaches the chain combinationally.
    assign bs.bs_ready     = (state_q == StFetch);
    assign ccff_shift_en   = (state_q == StShift);
    assign ccff_head       = ccff_shift_en & sr_q[0];
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign err             = err_q;
    assign tail_ones       = tail_ones_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 12-bit chain (8-bit words) and a 1-bit chain.
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- 12-bit chain DUT ----------------
    logic       start12 = 1'b0, abort12 = 1'b0;
    logic       head12, sh12, tail12, busy12, done12, err12;
    logic [3:0] ones12;
    ccff_chain_loader_if #(.DATA_W(8)) bs12 ();

    ccff_chain_loader #(.CHAIN_LEN(12), .DATA_W(8)) dut12 (
        .prog_clk      (clk),
        .pReset        (rst),
        .start         (start12),
        .abort         (abort12),
        .bs            (bs12.slave),
        .ccff_head     (head12),
        .ccff_shift_en (sh12),
        .ccff_tail     (tail12),
        .busy          (busy12),
        .done          (done12),
        .err           (err12),
        .tail_ones     (ones12)
    );

    // Chain model: head enters bit 0, tail is bit 11, shifts on edges with shift_en.
    logic [11:0] chain12;
    logic [11:0] preload_val = '0;
    logic        preload_req = 1'b0;
    assign tail12 = chain12[11];
    always @(posedge clk) begin
        if (preload_req) chain12 <= preload_val;
        else if (sh12) chain12 <= {chain12[10:0], head12};
    end

    // ---------------- 1-bit chain DUT ----------------
    logic       start1 = 1'b0;
    logic       head1, sh1, busy1, done1, err1;
    logic [0:0] ones1;
    ccff_chain_loader_if #(.DATA_W(8)) bs1 ();

    ccff_chain_loader #(.CHAIN_LEN(1), .DATA_W(8)) dut1 (
        .prog_clk      (clk),
        .pReset        (rst),
        .start         (start1),
        .abort         (1'b0),
        .bs            (bs1.slave),
        .ccff_head     (head1),
        .ccff_shift_en (sh1),
        .ccff_tail     (1'b0),
        .busy          (busy1),
        .done          (done1),
        .err           (err1),
        .tail_ones     (ones1)
    );

    // ---------------- scoreboards ----------------
    typedef struct {
        int cyc;
        int ones;
    } done_t;

    bit    q_head[$];
    done_t q_done[$];
    bit    q1_head[$];
    done_t q1_done[$];
    done_t e12, e1;
    int    t0 = 0, t1 = 0;
    int    sh_cnt = 0, hs_cnt = 0, hs1_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sh12) begin
                sh_cnt++;
                chk("shift_expected", int'(q_head.size() != 0), 1);
                if (q_head.size() != 0) chk("ccff_head", head12, q_head.pop_front());
            end else begin
                chk("head_idle_zero", head12, 0);
            end
            if (bs12.bs_valid && bs12.bs_ready) hs_cnt++;
            if (done12) begin
                chk("done_expected", int'(q_done.size() != 0), 1);
                if (q_done.size() != 0) begin
                    e12 = q_done.pop_front();
                    chk("done_cycle", cyc - t0 + 1, e12.cyc);
                    chk("tail_ones", ones12, e12.ones);
                end
            end
            if (sh1) begin
                chk("shift1_expected", int'(q1_head.size() != 0), 1);
                if (q1_head.size() != 0) chk("ccff_head1", head1, q1_head.pop_front());
            end
            if (bs1.bs_valid && bs1.bs_ready) hs1_cnt++;
            if (done1) begin
                chk("done1_expected", int'(q1_done.size() != 0), 1);
                if (q1_done.size() != 0) begin
                    e1 = q1_done.pop_front();
                    chk("done1_cycle", cyc - t1 + 1, e1.cyc);
                    chk("tail_ones1", ones1, e1.ones);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [11:0] v);
        @(negedge clk);
        preload_val = v;
        preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
    endtask

    task automatic push_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) q_head.push_back(w[i]);
    endtask

    task automatic push_done(input int c, input int ones);
        done_t d;
        d.cyc  = c;
        d.ones = ones;
        q_done.push_back(d);
    endtask

    task automatic do_start();
        @(negedge clk);
        start12 = 1'b1;
        @(posedge clk);
        #1 start12 = 1'b0;
        t0 = cyc;
    endtask

    task automatic feed(input logic [7:0] w, input int stall);
        int n = 0;
        @(negedge clk);
        while (!bs12.bs_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", bs12.bs_ready, 1);
        if (bs12.bs_ready) begin
            for (int i = 0; i < stall; i++) begin
                chk("stall_ready", bs12.bs_ready, 1);
                chk("stall_shift_en", sh12, 0);
                @(negedge clk);
            end
            bs12.bs_data  = w;
            bs12.bs_valid = 1'b1;
            @(posedge clk);
            #1 bs12.bs_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (busy12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", busy12, 0);
        chk("done_pending", q_done.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int sh_base, hs_base;

    initial begin
        bs12.bs_valid = 1'b0;
        bs12.bs_data  = '0;
        bs1.bs_valid  = 1'b0;
        bs1.bs_data   = '0;

        // Reset values
        preload(12'h0F0);
        @(negedge clk);
        chk("rst_ready", bs12.bs_ready, 0);
        chk("rst_head", head12, 0);
        chk("rst_shift_en", sh12, 0);
        chk("rst_busy", busy12, 0);
        chk("rst_done", done12, 0);
        chk("rst_err", err12, 0);
        chk("rst_tail_ones", ones12, 0);
        rst = 1'b0;

        // Basic load: 0xA5 then 0x03, chain preloaded with four ones
        sh_base = sh_cnt;
        hs_base = hs_cnt;
        push_bits(8'hA5, 8);
        push_bits(8'h03, 4);
        push_done(15, 4);
        do_start();
        feed(8'hA5, 0);
        feed(8'h03, 0);
        drain();
        chk("busy_low_cycle", cyc - t0 + 1, 16);
        chk("basic_shift_count", sh_cnt - sh_base, 12);
        chk("basic_handshakes", hs_cnt - hs_base, 2);
        chk("basic_chain", chain12, 12'hA5C);

        // Readback: all-ones chain, then all-zeros chain
        preload(12'hFFF);
        push_bits(8'h00, 8);
        push_bits(8'h00, 4);
        push_done(15, 12);
        do_start();
        feed(8'h00, 0);
        feed(8'h00, 0);
        drain();
        push_bits(8'h00, 8);
        push_bits(8'h00, 4);
        push_done(15, 0);
        do_start();
        feed(8'h00, 0);
        feed(8'h00, 0);
        drain();

        // Backpressure: five idle cycles in each FETCH delays done by ten
        preload(12'h000);
        sh_base = sh_cnt;
        push_bits(8'hA5, 8);
        push_bits(8'h03, 4);
        push_done(25, 0);
        do_start();
        feed(8'hA5, 5);
        feed(8'h03, 5);
        drain();
        chk("bp_shift_count", sh_cnt - sh_base, 12);
        chk("bp_chain", chain12, 12'hA5C);

        // Abort while idle is ignored
        @(negedge clk);
        abort12 = 1'b1;
        @(posedge clk);
        #1 abort12 = 1'b0;
        @(negedge clk);
        chk("idle_abort_err", err12, 0);
        chk("idle_abort_busy", busy12, 0);

        // Abort in the 4th SHIFT cycle
        preload(12'h000);
        sh_base = sh_cnt;
        push_bits(8'hA5, 4);
        do_start();
        feed(8'hA5, 0);
        repeat (4) @(negedge clk);
        abort12 = 1'b1;
        @(posedge clk);
        #1 abort12 = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy12, 0);
        chk("abort_err", err12, 1);
        chk("abort_shift_en", sh12, 0);
        repeat (3) @(negedge clk);
        chk("abort_shift_count", sh_cnt - sh_base, 4);
        chk("abort_head_left", q_head.size(), 0);

        // Next start clears err; chain holds 1,0,1,0 from the aborted load
        push_bits(8'hA5, 8);
        push_bits(8'h03, 4);
        push_done(15, 2);
        do_start();
        chk("start_clears_err", err12, 0);
        feed(8'hA5, 0);
        feed(8'h03, 0);
        drain();

        // Asynchronous reset mid-SHIFT
        push_bits(8'hA5, 8);
        do_start();
        feed(8'hA5, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", bs12.bs_ready, 0);
        chk("mid_rst_head", head12, 0);
        chk("mid_rst_shift_en", sh12, 0);
        chk("mid_rst_busy", busy12, 0);
        chk("mid_rst_done", done12, 0);
        chk("mid_rst_err", err12, 0);
        chk("mid_rst_tail_ones", ones12, 0);
        q_head.delete();
        @(negedge clk);
        rst = 1'b0;
        sh_base = sh_cnt;
        repeat (5) @(negedge clk);
        chk("post_rst_shift_count", sh_cnt - sh_base, 0);
        chk("post_rst_busy", busy12, 0);

        // CHAIN_LEN=1: word 0xFE shifts a single 0; start while busy ignored
        begin
            done_t d;
            d.cyc  = 3;
            d.ones = 0;
            q1_done.push_back(d);
            q1_head.push_back(1'b0);
        end
        hs_base = hs1_cnt;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        t1 = cyc;
        @(negedge clk);
        chk("len1_ready", bs1.bs_ready, 1);
        bs1.bs_data  = 8'hFE;
        bs1.bs_valid = 1'b1;
        @(posedge clk);
        #1 bs1.bs_valid = 1'b0;
        @(negedge clk);
        chk("len1_shift_en", sh1, 1);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("len1_busy", busy1, 0);
        chk("len1_handshakes", hs1_cnt - hs_base, 1);
        chk("len1_done_left", q1_done.size(), 0);
        chk("len1_err", err1, 0);

        chk("head_queue_empty", q_head.size(), 0);
        chk("head1_queue_empty", q1_head.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequencer that loads a configuration bitstream into a configuration-chain (ccff) shift register of fixed length. It accepts DATA_W-bit words over a valid/ready handshake and serializes them LSB-first onto `ccff_head`, asserting `ccff_shift_en` exactly CHAIN_LEN times. While loading, it counts the ones returned on `ccff_tail` as a readback checksum of the previous contents. It sits between the bitstream source (SPI/scan front-end) and the head of a tile's connection-block/switch-block ccff chain.

## Interface
- CHAIN_LEN, default 12: number of ccff bits in the chain; must be ≥ 1.
- DATA_W, default 8: bitstream word width; must be ≥ 1.
- CNT_W (localparam) = $clog2(CHAIN_LEN+1).

- prog_clk  in  1  programming clock; all state on its rising edge.
- pReset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- abort  in  1  cancels an in-progress load.
- bs_data  in  DATA_W  bitstream word; bit 0 is shifted first.
- bs_valid  in  1  bs_data is valid.
- bs_ready  out  1  loader accepts a word this cycle.
- ccff_head  out  1  serial data to the chain head.
- ccff_shift_en  out  1  chain clock enable; the chain shifts on every prog_clk edge where this is 1.
- ccff_tail  in  1  serial data from the chain tail.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when all CHAIN_LEN bits have been shifted.
- err  out  1  sticky abort flag; cleared by the next accepted start.
- tail_ones  out  CNT_W  count of 1s sampled on ccff_tail during shift cycles of the current/last load.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE: bs_ready=0, shift_en=0. On start=1, the block clears `remaining` to CHAIN_LEN, clears tail_ones and err, and moves to FETCH.
- FETCH: bs_ready=1. On bs_valid=1, it loads the word into shift register `sr` and sets `nbits` = min(DATA_W, remaining), then moves to SHIFT. With bs_valid=0, it stays in FETCH indefinitely.
- SHIFT: ccff_shift_en=1 and ccff_head=sr[0] every cycle. Each cycle: sr>>=1, nbits--, remaining--, and tail_ones += ccff_tail.
  - When nbits reaches 1 this cycle: if remaining==1, go to DONE; otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, then IDLE.
- Final word: when CHAIN_LEN mod DATA_W ≠ 0, the unused upper bits of the final word are discarded and never driven.
- Words consumed per load = ceil(CHAIN_LEN/DATA_W).
- Abort: abort=1 in FETCH or SHIFT forces IDLE on the next edge and sets err=1. shift_en drops the same edge. No done pulse. tail_ones holds its value.
- abort=1 in IDLE or DONE is ignored.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins.
- tail_ones saturates at CHAIN_LEN; it cannot exceed CHAIN_LEN by construction.
- ccff_head=0 whenever shift_en=0.

## Timing
- Reset values: state=IDLE, bs_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, err=0, tail_ones=0, and all internal counters 0.
- Reset takes effect immediately (asynchronous) and is released synchronously with prog_clk. Reset mid-load leaves the chain partially loaded; no further shift_en is issued.
- ccff_head and ccff_shift_en are registered outputs (driven from state/sr); there is no combinational path from inputs.
- bs_ready is a decode of state FETCH; the handshake completes on the edge where bs_valid & bs_ready.
- Each word costs one FETCH cycle plus nbits SHIFT cycles, so there is one bubble per word.
- With bs_valid held at 1 and the start edge as cycle 0, the load takes CHAIN_LEN + ceil(CHAIN_LEN/DATA_W) cycles; done is high in the cycle after the last shift.
- Defaults (12, 8): FETCH at cycle 1, SHIFT cycles 2–9, FETCH at cycle 10, SHIFT cycles 11–14, done at cycle 15, busy low from cycle 16.
- ccff_tail is sampled on the same edge that shifts the chain, i.e. before that edge's shift takes effect.

## Test plan
- Basic load (defaults): words 0xA5 then 0x03, bs_valid always 1 → ccff_head over the 12 shift cycles = 1,0,1,0,0,1,0,1,1,1,0,0; exactly 12 shift_en cycles; done at cycle 15; 2 handshakes.
- Readback: chain model preloaded with 12'hFFF, then load all zeros → tail_ones=12. A second load of 0x00/0x00 → tail_ones=0.
- Backpressure: bs_valid low for 5 cycles in each FETCH → bs_ready stays high, shift_en stays 0 during the stall, data is identical, done is delayed by 10 cycles.
- Abort: assert abort in the 4th SHIFT cycle → IDLE next edge, err=1, only 4 shift_en cycles, no done; the next start clears err.
- Reset mid-SHIFT: pReset asserted asynchronously between edges → all outputs read as their reset values before the next edge; no further shift_en after release.
- CHAIN_LEN=1, DATA_W=8: word 0xFE → one shift with ccff_head=0, done at cycle 3; start during busy is ignored (exactly one handshake).
